// File: rtl/modn_pkg.sv
// rtl/modn_pkg.sv - shared constants and next-count function for the modulo-N counter
package modn_pkg;

   localparam int MOD_MIN       = 2;
   localparam int DEFAULT_WIDTH = 5;
   localparam int DEFAULT_MOD   = 9;

   typedef struct packed {
      logic [31:0] count;
      logic        wrap;
   } count_t;

   // Width-agnostic next count: m is the modulus in force this period,
   // m_new the modulus that takes over if this step wraps (only used going down).
   function automatic count_t next_count(input logic [31:0] y,
                                         input logic [31:0] m,
                                         input logic [31:0] m_new,
                                         input logic        up);
      count_t r;
      r.wrap = up ? (y == m - 32'd1) : (y == 32'd0);
      if (r.wrap)
         r.count = up ? 32'd0 : m_new - 32'd1;
      else
         r.count = up ? y + 32'd1 : y - 32'd1;
      return r;
   endfunction

endpackage

// File: rtl/modn_counter_if.sv
// rtl/modn_counter_if.sv - control and status bundle of the modulo-N counter
interface modn_counter_if
   import modn_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] mod_val;
   logic [WIDTH-1:0] y;
   logic             tc;
   logic             wrap;
   logic             mod_err;

   modport master (
      output en, up, load, load_val, mod_val,
      input  y, tc, wrap, mod_err
   );

   modport slave (
      input  en, up, load, load_val, mod_val,
      output y, tc, wrap, mod_err
   );
endinterface

// File: rtl/modn_counter.sv
// rtl/modn_counter.sv - parametrised up/down modulo-N counter with load and cascade output
module modn_counter
   import modn_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int MOD_DEFAULT = DEFAULT_MOD
) (
   input  logic          clk,
   input  logic          rst,
   modn_counter_if.slave bus
);

   if (WIDTH < 2 || WIDTH > 31)
      $error("modn_counter: WIDTH must be in [2, 31]");
   if (MOD_DEFAULT < MOD_MIN || MOD_DEFAULT > (2 ** WIDTH) - 1)
      $error("modn_counter: MOD_DEFAULT must be in [2, 2^WIDTH-1]");

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MOD_MIN);
   localparam logic [WIDTH-1:0] RST_MOD = WIDTH'(MOD_DEFAULT);

   logic [WIDTH-1:0] y_q;
   logic [WIDTH-1:0] m_q;
   logic             wrap_q;
   logic             err_q;

   logic             mod_ok;
   logic [WIDTH-1:0] m_load;
   logic [WIDTH-1:0] y_load;
   logic             err_load;
   logic             term;
   logic [WIDTH-1:0] m_wrap;
   count_t           nc;

   // Next-state candidates for the load and count paths; mod_val only ever
   // reaches m_q through a load or a wrap, so a period is never shortened mid-way.
   always_comb begin
      mod_ok   = (bus.mod_val >= MIN_W);
      m_load   = mod_ok ? bus.mod_val : m_q;
      y_load   = (bus.load_val < m_load) ? bus.load_val : m_load - ONE;
      err_load = !mod_ok || !(bus.load_val < m_load);
      term     = bus.up ? (y_q == m_q - ONE) : (y_q == '0);
      m_wrap   = term ? m_load : m_q;
      nc       = next_count(32'(y_q), 32'(m_q), 32'(m_wrap), bus.up);
   end

   // State update with priority rst > load > en > hold; pulses clear on every non-causing edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q    <= '0;
         m_q    <= RST_MOD;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else if (bus.load) begin
         y_q    <= y_load;
         m_q    <= m_load;
         wrap_q <= 1'b0;
         err_q  <= err_load;
      end else if (bus.en) begin
         y_q    <= WIDTH'(nc.count);
         m_q    <= m_wrap;
         wrap_q <= nc.wrap;
         err_q  <= nc.wrap && !mod_ok;
      end else begin
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end
   end

   assign bus.y       = y_q;
   assign bus.wrap    = wrap_q;
   assign bus.mod_err = err_q;
   assign bus.tc      = bus.en & (bus.up ? (y_q == m_q - ONE) : (y_q == '0));

endmodule

// File: tb/tb_modn_counter.sv
// tb/tb_modn_counter.sv - directed and random checks of modn_counter against an arithmetic model
module tb_modn_counter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   modn_counter_if #(.WIDTH(5)) bus();

   modn_counter #(.WIDTH(5), .MOD_DEFAULT(9)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   int my = 0;
   int mm = 9;
   int ew = 0;
   int ee = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit e, input bit u, input bit l,
                      input int lv, input int mv);
      bit wrapping;
      int old_m;
      rst          = r;
      bus.en       = e;
      bus.up       = u;
      bus.load     = l;
      bus.load_val = 5'(lv);
      bus.mod_val  = 5'(mv);
      #1;
      chk("tc", 32'(bus.tc), (e && (u ? (my == mm - 1) : (my == 0))) ? 1 : 0);
      if (r) begin
         my = 0; mm = 9; ew = 0; ee = 0;
      end else if (l) begin
         ew = 0; ee = 0;
         if (mv >= 2) mm = mv; else ee = 1;
         if (lv < mm) my = lv;
         else begin my = mm - 1; ee = 1; end
      end else if (e) begin
         old_m    = mm;
         wrapping = u ? (my == mm - 1) : (my == 0);
         ew = wrapping ? 1 : 0;
         ee = 0;
         if (wrapping) begin
            if (mv >= 2) mm = mv; else ee = 1;
         end
         if (u) my = (my + 1) % old_m;
         else   my = wrapping ? mm - 1 : my - 1;
      end else begin
         ew = 0; ee = 0;
      end
      @(posedge clk);
      #1;
      chk("y", 32'(bus.y), my);
      chk("wrap", 32'(bus.wrap), ew);
      chk("mod_err", 32'(bus.mod_err), ee);
   endtask

   int mv_r;
   bit up_r;

   initial begin
      bus.en = 0; bus.up = 1; bus.load = 0; bus.load_val = '0; bus.mod_val = 5'd9;

      // reset state
      cyc(1, 0, 1, 0, 0, 9);
      chk("reset_y", 32'(bus.y), 0);

      // 1: up count through two wraps
      for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 0, 9);
      chk("s1_y_after_20", 32'(bus.y), 20 % 9);

      // 2: down count from reset
      cyc(1, 0, 0, 0, 0, 9);
      for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0, 9);
      chk("s2_y_after_12", 32'(bus.y), 6);

      // 3: deferred modulus, mod_val raised to 12 at y=3
      cyc(1, 0, 1, 0, 0, 9);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 9);
      for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 12);
      chk("s3_first_wrap", 32'(bus.wrap), 1);
      for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 12);
      chk("s3_second_wrap", 32'(bus.wrap), 1);

      // 4: load clamp
      cyc(0, 1, 1, 1, 20, 12);
      chk("s4_y", 32'(bus.y), 11);
      chk("s4_err", 32'(bus.mod_err), 1);
      chk("s4_wrap", 32'(bus.wrap), 0);
      cyc(0, 0, 1, 0, 0, 12);
      chk("s4_err_clear", 32'(bus.mod_err), 0);

      // 5: illegal modulus held across wraps
      cyc(1, 0, 1, 0, 0, 9);
      for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0, 1);
      chk("s5_wrap", 32'(bus.wrap), 1);
      chk("s5_err", 32'(bus.mod_err), 1);
      for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0, 1);
      chk("s5_period9", 32'(bus.wrap), 1);

      // 6: reset together with load and en at y=5
      cyc(1, 0, 1, 0, 0, 9);
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 9);
      cyc(1, 1, 1, 1, 7, 12);
      chk("s6_y", 32'(bus.y), 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, 12);
      chk("s6_hold", 32'(bus.y), 0);

      // random traffic
      mv_r = 9;
      up_r = 1;
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if ($urandom_range(0, 9) == 0)
            mv_r = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 31);
         if ($urandom_range(0, 15) == 0) up_r = ~up_r;
         cyc(r < 2, $urandom_range(0, 7) != 0, up_r, (r >= 2 && r < 8),
             $urandom_range(0, 31), mv_r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL timeout: observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
